// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between the instruction fetch and data load/store requesters.
// Define ARB_FAIR_EN to add a data-streak counter that bounds how long instruction fetch can be starved.
module memory_arbiter #(
    parameter int WORD_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);
    // state  | meaning
    // IDLE   | no grant; RAM controls quiet, both waits high
    // DGRANT | data requester drives the RAM until ACCESS or it drops its request
    // IGRANT | instruction requester drives the RAM until ACCESS or it drops its request
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    if (MAX_DATA_STREAK < 1) begin : g_bad_streak
        $error("MAX_DATA_STREAK must be at least 1");
    end

    state_t state_q, state_d;
    logic   d_req;
    logic   ram_done;
    logic   d_done;
    logic   i_done;
    logic   force_i;

    assign d_req    = dREN | dWEN;
    assign ram_done = (ramstate == RAM_ACCESS);
    // A request that drops in the same cycle as ACCESS counts as an abort, not a completion.
    assign d_done   = (state_q == DGRANT) && d_req && ram_done;
    assign i_done   = (state_q == IGRANT) && iREN && ram_done;

`ifdef ARB_FAIR_EN
    localparam int                  STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;

    always_comb begin
        streak_d = streak_q;
        if (!iREN || i_done) begin
            streak_d = '0;
        end else if (d_done && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_i = (streak_q == STREAK_MAX);
`else
    assign force_i = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_req && !(force_i && iREN)) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end
            DGRANT: begin
                if (!d_req || d_done) begin
                    state_d = IDLE;
                end
            end
            IGRANT: begin
                if (!iREN || i_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        case (state_q)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (d_done) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (i_done) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed vectors push expected completions, a monitor pops and compares.
// Build with ARB_FAIR_EN defined to check the fairness pattern instead of strict data priority.
module tb_memory_arbiter;
    localparam int W = 32;
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         iREN, dREN, dWEN;
    logic [W-1:0] iaddr, daddr, dstore, ramload;
    logic [1:0]   ramstate;
    logic         iwait, dwait, ramREN, ramWEN;
    logic [W-1:0] iload, dload, ramaddr, ramstore;

    typedef struct packed {
        logic         is_d;
        logic [W-1:0] load;
        logic [W-1:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   i_cnt = 0;
    int   d_cnt = 0;

    memory_arbiter #(.WORD_W(W), .MAX_DATA_STREAK(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic ctl(input string name, input logic ren, input logic wen,
                       input logic [W-1:0] addr, input logic [W-1:0] store);
        chk({name, "_ren"}, {31'b0, ramREN}, {31'b0, ren});
        chk({name, "_wen"}, {31'b0, ramWEN}, {31'b0, wen});
        chk({name, "_addr"}, ramaddr, addr);
        chk({name, "_store"}, ramstore, store);
    endtask

    task automatic waits(input string name, input logic iw, input logic dw);
        chk({name, "_waits"}, {30'b0, iwait, dwait}, {30'b0, iw, dw});
    endtask

    task automatic expect_done(input logic is_d, input logic [W-1:0] ld, input logic [W-1:0] addr);
        exp_t e;
        e.is_d = is_d;
        e.load = ld;
        e.addr = addr;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    // Monitor: every completion must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (iwait === 1'b0 || dwait === 1'b0) begin
                if (dwait === 1'b0) d_cnt++;
                if (iwait === 1'b0) i_cnt++;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", {30'b0, iwait, dwait}, 32'h3);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_waits", {30'b0, iwait, dwait}, {30'b0, e.is_d, ~e.is_d});
                    chk("sb_load", e.is_d ? dload : iload, e.load);
                    chk("sb_other_load", e.is_d ? iload : dload, 32'h0);
                    chk("sb_addr", ramaddr, e.addr);
                end
            end else begin
                chk("idle_loads", iload | dload, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int nacc;
        int i0;
        nRST = 1'b1;
        iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
        iaddr = 32'h10; daddr = 32'h20; dstore = 32'h77;
        ramstate = ACC; ramload = 32'h12345678;
        #1 nRST = 1'b0;

        // Reset held with every request high
        repeat (2) begin
            smp();
            ctl("rst", 1'b0, 1'b0, 32'h0, 32'h0);
            waits("rst", 1'b1, 1'b1);
            step();
        end

        // Release: first grant one edge later
        nRST = 1'b1; dREN = 1'b0; dWEN = 1'b0; ramload = 32'h11111111;
        expect_done(1'b0, 32'h11111111, 32'h10);
        smp(); ctl("rel_idle", 1'b0, 1'b0, 32'h0, 32'h0);
        step(); smp(); ctl("first_grant", 1'b1, 1'b0, 32'h10, 32'h0);
        step(); iREN = 1'b0; ramstate = FREE;
        smp(); ctl("first_after", 1'b0, 1'b0, 32'h0, 32'h0);

        // Instruction read: BUSY, BUSY, ACCESS
        step(); iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
        expect_done(1'b0, 32'h8C010004, 32'h40);
        smp(); ctl("i_idle", 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) begin
            step(); smp();
            ctl("i_busy", 1'b1, 1'b0, 32'h40, 32'h0);
            waits("i_busy", 1'b1, 1'b1);
        end
        step(); ramstate = ACC; ramload = 32'h8C010004;
        smp(); ctl("i_access", 1'b1, 1'b0, 32'h40, 32'h0);
        step(); iREN = 1'b0; ramstate = FREE;
        smp(); ctl("i_back_idle", 1'b0, 1'b0, 32'h0, 32'h0); waits("i_back_idle", 1'b1, 1'b1);

        // Contention: data write first, one idle cycle, then instruction
        step(); iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        ramstate = ACC; ramload = 32'h55AA55AA;
        expect_done(1'b1, 32'h55AA55AA, 32'h100);
        expect_done(1'b0, 32'h0BADF00D, 32'h80);
        smp(); ctl("cont_idle", 1'b0, 1'b0, 32'h0, 32'h0);
        step(); smp(); ctl("cont_d", 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
        step(); dWEN = 1'b0; ramload = 32'h0BADF00D;
        smp(); ctl("cont_gap", 1'b0, 1'b0, 32'h0, 32'h0); waits("cont_gap", 1'b1, 1'b1);
        step(); smp(); ctl("cont_i", 1'b1, 1'b0, 32'h80, 32'h0);
        step(); iREN = 1'b0;
        smp(); ctl("cont_end", 1'b0, 1'b0, 32'h0, 32'h0);

        // Abort: data read dropped during BUSY
        step(); dREN = 1'b1; daddr = 32'h200; dstore = 32'h1234; ramstate = BUSY;
        smp(); ctl("ab_idle0", 1'b0, 1'b0, 32'h0, 32'h0);
        step(); smp(); ctl("ab_grant", 1'b1, 1'b0, 32'h200, 32'h1234);
        step(); dREN = 1'b0;
        smp(); ctl("ab_drop", 1'b0, 1'b0, 32'h200, 32'h1234); waits("ab_drop", 1'b1, 1'b1);
        repeat (2) begin
            step(); ramstate = ACC;
            smp(); ctl("ab_after", 1'b0, 1'b0, 32'h0, 32'h0); waits("ab_after", 1'b1, 1'b1);
        end

        // ERROR three cycles, then ACCESS
        step(); dREN = 1'b1; daddr = 32'h300; dstore = 32'h0; ramstate = ERR;
        expect_done(1'b1, 32'h13579BDF, 32'h300);
        smp(); ctl("err_idle", 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) begin
            step(); smp();
            ctl("err_hold", 1'b1, 1'b0, 32'h300, 32'h0);
            waits("err_hold", 1'b1, 1'b1);
        end
        step(); ramstate = ACC; ramload = 32'h13579BDF;
        smp(); ctl("err_access", 1'b1, 1'b0, 32'h300, 32'h0);
        step(); dREN = 1'b0; ramstate = FREE;
        smp(); ctl("err_end", 1'b0, 1'b0, 32'h0, 32'h0);

        // Sustained contention: strict priority, or 4 data then 1 instruction
        nacc = FAIR ? 25 : 20;
        step(); iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h400;
        ramstate = ACC; ramload = 32'hA5A50000;
        i0 = i_cnt;
        for (int k = 0; k < nacc; k++) begin
            if (FAIR && (k % 5 == 4)) expect_done(1'b0, 32'hA5A50000, 32'h44);
            else                      expect_done(1'b1, 32'hA5A50000, 32'h400);
        end
        smp();
        repeat (2 * nacc - 1) begin
            step(); smp();
        end
        step(); iREN = 1'b0; dREN = 1'b0;
        smp();
        chk("stream_i_count", i_cnt - i0, FAIR ? 32'd5 : 32'd0);

        repeat (3) begin
            step(); smp();
        end
        chk("sb_drain", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
